// File: rtl/sdrstick_rx_framer_if.sv
// Signal bundle for sdrstick_rx_framer: show-ahead FIFO read side, Avalon-ST source and CPU register port.
// master = framer side, slave = surrounding system (FIFO, sink, CPU).
interface sdrstick_rx_framer_if;
    logic [31:0] fifo_readdata;
    logic        fifo_empty;
    logic        fifo_read;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_startofpacket;
    logic        out_endofpacket;
    logic        out_ready;
    logic [1:0]  ctl_address;
    logic        ctl_read;
    logic        ctl_write;
    logic [31:0] ctl_writedata;
    logic [31:0] ctl_readdata;

    modport master (
        input  fifo_readdata, fifo_empty, out_ready,
        input  ctl_address, ctl_read, ctl_write, ctl_writedata,
        output fifo_read, out_data, out_valid, out_startofpacket, out_endofpacket, ctl_readdata
    );

    modport slave (
        output fifo_readdata, fifo_empty, out_ready,
        output ctl_address, ctl_read, ctl_write, ctl_writedata,
        input  fifo_read, out_data, out_valid, out_startofpacket, out_endofpacket, ctl_readdata
    );
endinterface

// File: rtl/sdrstick_rx_framer.sv
// Packs 24-bit I/Q sample pairs from a show-ahead FIFO into headered Avalon-ST frames (3 words per 2 pairs).
// Define SDRSTICK_FRAMER_CRC_EN to append an XOR trailer word carrying the end-of-packet marker.
module sdrstick_rx_framer (
    input  logic                 clk,
    input  logic                 reset_n,
    sdrstick_rx_framer_if.master bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR     = 3'd1,
        COLLECT = 3'd2,
        W0      = 3'd3,
        W1      = 3'd4,
        W2      = 3'd5
`ifdef SDRSTICK_FRAMER_CRC_EN
        , TRL   = 3'd6
`endif
    } state_t;

    function automatic logic [7:0] latch_len(input logic [7:0] raw);
        logic [7:0] even;
        even = {raw[7:1], 1'b0};
        return (even == 8'd0) ? 8'd2 : even;
    endfunction

    function automatic logic [31:0] fold_word(input logic [31:0] acc, input logic [31:0] word);
        return acc ^ word;
    endfunction

    state_t           state_r, state_s;
    logic             enable_r;
    logic [7:0]       frame_len_r, lat_s;
    logic [7:0]       seq_r, seq_s, len_r, len_s;
    logic [31:0]      count_r, count_s, crc_r, crc_s, rdata_r;
    logic [6:0]       grp_r, grp_s;
    logic [1:0]       idx_r, idx_s;
    logic [3:0][23:0] smp_r, smp_s;
    logic             pop_s, accept_s, frame_end_s;
    logic [31:0]      data_r, data_s;
    logic             valid_r, valid_s, sop_r, sop_s, eop_r, eop_s;
    logic             unused_s;

    // Next-state, sample capture and frame bookkeeping
    always_comb begin
        state_s     = state_r;
        len_s       = len_r;
        grp_s       = grp_r;
        idx_s       = idx_r;
        smp_s       = smp_r;
        crc_s       = crc_r;
        seq_s       = seq_r;
        count_s     = count_r;
        pop_s       = 1'b0;
        frame_end_s = 1'b0;
        lat_s       = latch_len(frame_len_r);
        accept_s    = valid_r & bus.out_ready;
        case (state_r)
            IDLE: begin
                if (enable_r) begin
                    state_s = HDR;
                    len_s   = lat_s;
                    grp_s   = lat_s[7:1];
                end else begin
                    state_s = IDLE;
                end
            end
            HDR: begin
                if (accept_s) begin
                    state_s = COLLECT;
                    idx_s   = 2'd0;
                    crc_s   = 32'd0;
                end else begin
                    state_s = HDR;
                end
            end
            COLLECT: begin
                if (!bus.fifo_empty) begin
                    pop_s        = 1'b1;
                    smp_s[idx_r] = bus.fifo_readdata[23:0];
                    idx_s        = idx_r + 2'd1;
                    if (idx_r == 2'd3) begin
                        state_s = W0;
                    end else begin
                        state_s = COLLECT;
                    end
                end else begin
                    state_s = COLLECT;
                end
            end
            W0: begin
                if (accept_s) begin
                    crc_s   = fold_word(crc_r, data_r);
                    state_s = W1;
                end else begin
                    state_s = W0;
                end
            end
            W1: begin
                if (accept_s) begin
                    crc_s   = fold_word(crc_r, data_r);
                    state_s = W2;
                end else begin
                    state_s = W1;
                end
            end
            W2: begin
                if (accept_s) begin
                    crc_s = fold_word(crc_r, data_r);
                    if (grp_r == 7'd1) begin
`ifdef SDRSTICK_FRAMER_CRC_EN
                        state_s = TRL;
`else
                        frame_end_s = 1'b1;
`endif
                    end else begin
                        grp_s   = grp_r - 7'd1;
                        state_s = COLLECT;
                    end
                end else begin
                    state_s = W2;
                end
            end
`ifdef SDRSTICK_FRAMER_CRC_EN
            TRL: begin
                if (accept_s) begin
                    frame_end_s = 1'b1;
                end else begin
                    state_s = TRL;
                end
            end
`endif
            default: state_s = IDLE;
        endcase
        // Enable and frame_len are only sampled here, so mid-frame writes wait for the next frame
        if (frame_end_s) begin
            seq_s   = seq_r + 8'd1;
            count_s = count_r + 32'd1;
            if (enable_r) begin
                state_s = HDR;
                len_s   = lat_s;
                grp_s   = lat_s[7:1];
            end else begin
                state_s = IDLE;
            end
        end else begin
            seq_s = seq_r;
        end
    end

    // Source word for the state being entered, so the outputs can be registered
    always_comb begin
        data_s  = 32'd0;
        valid_s = 1'b0;
        sop_s   = 1'b0;
        eop_s   = 1'b0;
        case (state_s)
            HDR: begin
                data_s  = {8'hA5, seq_s, 8'h00, len_s};
                valid_s = 1'b1;
                sop_s   = 1'b1;
            end
            W0: begin
                data_s  = {smp_s[0], smp_s[1][23:16]};
                valid_s = 1'b1;
            end
            W1: begin
                data_s  = {smp_s[1][15:0], smp_s[2][23:8]};
                valid_s = 1'b1;
            end
            W2: begin
                data_s  = {smp_s[2][7:0], smp_s[3]};
                valid_s = 1'b1;
`ifdef SDRSTICK_FRAMER_CRC_EN
                eop_s   = 1'b0;
`else
                eop_s   = (grp_s == 7'd1);
`endif
            end
`ifdef SDRSTICK_FRAMER_CRC_EN
            TRL: begin
                data_s  = crc_s;
                valid_s = 1'b1;
                eop_s   = 1'b1;
            end
`endif
            default: data_s = 32'd0;
        endcase
    end

    // Framer state, datapath and registered source outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            len_r   <= 8'd0;
            grp_r   <= 7'd0;
            idx_r   <= 2'd0;
            smp_r   <= 96'd0;
            crc_r   <= 32'd0;
            seq_r   <= 8'd0;
            count_r <= 32'd0;
            data_r  <= 32'd0;
            valid_r <= 1'b0;
            sop_r   <= 1'b0;
            eop_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            len_r   <= len_s;
            grp_r   <= grp_s;
            idx_r   <= idx_s;
            smp_r   <= smp_s;
            crc_r   <= crc_s;
            seq_r   <= seq_s;
            count_r <= count_s;
            data_r  <= data_s;
            valid_r <= valid_s;
            sop_r   <= sop_s;
            eop_r   <= eop_s;
        end
    end

    // CPU register writes and one-cycle-latency reads; a write wins over a simultaneous read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_r    <= 1'b0;
            frame_len_r <= 8'd64;
            rdata_r     <= 32'd0;
        end else if (bus.ctl_write) begin
            case (bus.ctl_address)
                2'd0:    enable_r    <= bus.ctl_writedata[0];
                2'd1:    frame_len_r <= bus.ctl_writedata[7:0];
                default: enable_r    <= enable_r;
            endcase
        end else if (bus.ctl_read) begin
            case (bus.ctl_address)
                2'd0:    rdata_r <= {31'd0, enable_r};
                2'd1:    rdata_r <= {24'd0, frame_len_r};
                2'd2:    rdata_r <= {24'd0, seq_r};
                default: rdata_r <= count_r;
            endcase
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign bus.fifo_read         = pop_s;
    assign bus.out_data          = data_r;
    assign bus.out_valid         = valid_r;
    assign bus.out_startofpacket = sop_r;
    assign bus.out_endofpacket   = eop_r;
    assign bus.ctl_readdata      = rdata_r;
    assign unused_s              = ^{bus.fifo_readdata[31:24], bus.ctl_writedata[31:8]};
endmodule
